mem_sequencer: RTL and testbench
================================

MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 The block SHALL have the parameter TIMEOUT, default 8'd255: the number of wait cycles in one access before the timeout flag is raised.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the port mem_op_valid, input, 1 bit: the MEM-stage latch holds a valid instruction.
REQ-005 The block SHALL have the port mem_op, input, lc3b_memop: the memory operation, one of MOP_NONE, MOP_LD, MOP_ST, MOP_LDI, MOP_STI.
REQ-006 The block SHALL have the port dcache_resp, input, 1 bit: D-cache access complete.
REQ-007 The block SHALL have the ports dcache_read and dcache_write, output, 1 bit each: D-cache strobes.
REQ-008 The block SHALL have the port indirectmux_sel, output, 1 bit: MEM address source; 0 is the ALU result, 1 is the indirect save register.
REQ-009 The block SHALL have the port load_save, output, 1 bit: capture the D-cache read data into the indirect save register.
REQ-010 The block SHALL have the port save_valid, output, 1 bit: the save register holds the live pointer, qualifying forward_save.
REQ-011 The block SHALL have the port stall_pipe, output, 1 bit: freeze the IF through MEM latches.
REQ-012 The block SHALL have the port mem_done, output, 1 bit: one-cycle pulse when the operation retires from MEM.
REQ-013 The block SHALL have the port mem_timeout, output, 1 bit: sticky watchdog flag.
REQ-014 The block SHALL have the port access_count, output, 16 bits: completed D-cache accesses, wrapping.

Function
REQ-015 The block SHALL implement the states IDLE, FIRST, SECOND and DONE.
REQ-016 In IDLE, when mem_op_valid=1 and mem_op!=MOP_NONE, the block SHALL assert stall_pipe combinationally, latch mem_op into op_q, and enter FIRST; otherwise it SHALL remain in IDLE with stall_pipe=0.
REQ-017 In FIRST, the block SHALL hold indirectmux_sel=0 and stall_pipe=1, drive dcache_write=1 for MOP_ST, and drive dcache_read=1 for MOP_LD, MOP_LDI and MOP_STI.
REQ-018 In FIRST with dcache_resp=1, the block SHALL enter DONE for LD/ST; for LDI/STI it SHALL assert load_save=1 for that cycle and enter SECOND.
REQ-019 In SECOND, the block SHALL hold indirectmux_sel=1, stall_pipe=1 and save_valid=1, drive dcache_read=1 for LDI and dcache_write=1 for STI, and enter DONE on dcache_resp=1.
REQ-020 In DONE, the block SHALL hold stall_pipe=0 and mem_done=1, hold save_valid=1 only if op_q is LDI/STI, and unconditionally return to IDLE.
REQ-021 Minimum latency SHALL be: LD/ST 3 cycles from acceptance to mem_done (1 response cycle); LDI/STI 4 cycles.
REQ-022 The block SHALL decode from op_q only after acceptance; changes on mem_op or mem_op_valid during FIRST/SECOND SHALL be ignored.
REQ-023 The block SHALL ignore dcache_resp in IDLE and DONE, and the D-cache strobes SHALL be 0 in those states.
REQ-024 dcache_read and dcache_write SHALL never be asserted together.
REQ-025 The wait counter SHALL clear on entry to FIRST and to SECOND and increment each FIRST/SECOND cycle without dcache_resp, saturating at TIMEOUT.
REQ-026 On reaching TIMEOUT, the block SHALL set mem_timeout, which SHALL stay set until reset; the sequencer keeps waiting.
REQ-027 access_count SHALL increment by 1 on each dcache_resp accepted in FIRST or SECOND, wrapping from 16'hFFFF to 0.

Reset
REQ-028 While reset_n=0, the block SHALL asynchronously force state IDLE, op_q=MOP_NONE, wait counter 0, mem_timeout 0 and access_count 0.
REQ-029 Reset asserted mid-access SHALL drop the request immediately, with all outputs 0 including the strobes and stall_pipe.
REQ-030 In the first cycle after reset release, the block SHALL accept a pending op per REQ-016.

Structure
REQ-031 The lc3b_memop enum and the mem_seq_state enum {IDLE, FIRST, SECOND, DONE} SHALL be defined in lc3b_types.
REQ-032 The wait counter and timeout compare SHALL be the sub-module mem_wait_counter, with ports clk, reset_n, clear, enable and expired.
REQ-033 The next-state/output logic and the state register SHALL be separated into an always_comb block and an always_ff block.

Verification
REQ-034 The bench SHALL apply MOP_LD valid with dcache_resp 2 cycles after the read rises; it SHALL see dcache_read high for 2 cycles, mem_done pulsed once, stall_pipe low in DONE, and access_count=1.
REQ-035 The bench SHALL apply MOP_LDI with 1-cycle responses; it SHALL see load_save with the first response, indirectmux_sel=1 in SECOND, mem_done at cycle 4, and access_count=2.
REQ-036 The bench SHALL apply MOP_STI; it SHALL see a read in FIRST, then a write in SECOND with indirectmux_sel=1, and never both strobes asserted.
REQ-037 The bench SHALL drive mem_op from MOP_ST to MOP_LD during FIRST; the block SHALL still issue a write only, with op_q held.
REQ-038 The bench SHALL withhold dcache_resp for 300 cycles; mem_timeout SHALL rise after TIMEOUT cycles and stay high after a later response until reset_n=0.
REQ-039 The bench SHALL pulse reset_n low during SECOND of an LDI; all outputs SHALL drop to 0 asynchronously, with the block in IDLE on release and access_count=0.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b MEM-stage types: memory operation codes and sequencer states.
package lc3b_types;

  typedef enum logic [2:0] {
    MOP_NONE = 3'd0,
    MOP_LD   = 3'd1,
    MOP_ST   = 3'd2,
    MOP_LDI  = 3'd3,
    MOP_STI  = 3'd4
  } lc3b_memop;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2,
    DONE   = 2'd3
  } mem_seq_state;

  // Indirect ops need a pointer fetch before the real access.
  function automatic logic is_indirect(input lc3b_memop op);
    return (op == MOP_LDI) || (op == MOP_STI);
  endfunction

endpackage

// File: rtl/mem_sequencer_if.sv
// MEM-stage request / D-cache handshake bundle for mem_sequencer.
import lc3b_types::*;

interface mem_sequencer_if;
  logic        mem_op_valid;
  lc3b_memop   mem_op;
  logic        dcache_resp;
  logic        dcache_read;
  logic        dcache_write;
  logic        indirectmux_sel;
  logic        load_save;
  logic        save_valid;
  logic        stall_pipe;
  logic        mem_done;
  logic        mem_timeout;
  logic [15:0] access_count;

  modport master (
    output mem_op_valid, mem_op, dcache_resp,
    input  dcache_read, dcache_write, indirectmux_sel, load_save, save_valid,
           stall_pipe, mem_done, mem_timeout, access_count
  );

  modport slave (
    input  mem_op_valid, mem_op, dcache_resp,
    output dcache_read, dcache_write, indirectmux_sel, load_save, save_valid,
           stall_pipe, mem_done, mem_timeout, access_count
  );
endinterface

// File: rtl/mem_sequencer_wait_counter.sv
// Per-access wait-cycle counter; saturates at TIMEOUT and flags expiry.
module mem_wait_counter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && (count != TIMEOUT))
      count <= count + 8'd1;
  end

  assign expired = (count == TIMEOUT);

endmodule

// File: rtl/mem_sequencer.sv
// MEM-stage D-cache sequencer: direct (LD/ST) and two-access indirect (LDI/STI) ops.
import lc3b_types::*;

module mem_sequencer #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic            clk,
  input  logic            reset_n,
  mem_sequencer_if.slave  bus
);

  mem_seq_state state_q, state_d;
  lc3b_memop    op_q, op_d;
  logic         cnt_clear, cnt_enable, expired;
  logic         resp_taken;
  logic         timeout_q;
  logic [15:0]  access_q;

  logic rd, wr, mux_sel, ld_save, sv_valid, stall, done;

  mem_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    resp_taken = 1'b0;
    rd         = 1'b0;
    wr         = 1'b0;
    mux_sel    = 1'b0;
    ld_save    = 1'b0;
    sv_valid   = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.mem_op_valid && (bus.mem_op != MOP_NONE)) begin
          stall     = 1'b1;
          op_d      = bus.mem_op;
          cnt_clear = 1'b1;
          state_d   = FIRST;
        end
      end
      FIRST: begin
        stall = 1'b1;
        wr    = (op_q == MOP_ST);
        rd    = (op_q == MOP_LD) || is_indirect(op_q);
        if (bus.dcache_resp) begin
          resp_taken = 1'b1;
          if (is_indirect(op_q)) begin
            ld_save   = 1'b1;
            cnt_clear = 1'b1;
            state_d   = SECOND;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_enable = 1'b1;
        end
      end
      SECOND: begin
        stall    = 1'b1;
        mux_sel  = 1'b1;
        sv_valid = 1'b1;
        rd       = (op_q == MOP_LDI);
        wr       = (op_q == MOP_STI);
        if (bus.dcache_resp) begin
          resp_taken = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      DONE: begin
        done     = 1'b1;
        sv_valid = is_indirect(op_q);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= MOP_NONE;
      timeout_q <= 1'b0;
      access_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      timeout_q <= timeout_q | expired;
      if (resp_taken)
        access_q <= access_q + 16'd1;
    end
  end

  // Gating with reset_n keeps the combinational IDLE stall from leaking out while in reset.
  assign bus.dcache_read     = reset_n & rd;
  assign bus.dcache_write    = reset_n & wr;
  assign bus.indirectmux_sel = reset_n & mux_sel;
  assign bus.load_save       = reset_n & ld_save;
  assign bus.save_valid      = reset_n & sv_valid;
  assign bus.stall_pipe      = reset_n & stall;
  assign bus.mem_done        = reset_n & done;
  assign bus.mem_timeout     = reset_n & (timeout_q | expired);
  assign bus.access_count    = access_q;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed self-checking bench for mem_sequencer.
import lc3b_types::*;

module tb_mem_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic both_seen = 1'b0;

  mem_sequencer_if bus ();

  mem_sequencer #(.TIMEOUT(8'd255)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (bus.dcache_read && bus.dcache_write) both_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n          = 1'b0;
    bus.mem_op_valid = 1'b0;
    bus.mem_op       = MOP_NONE;
    bus.dcache_resp  = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
  endtask

  initial begin
    do_reset();
    check("rst_stall",  32'(bus.stall_pipe), 32'd0);
    check("rst_done",   32'(bus.mem_done), 32'd0);
    check("rst_tmo",    32'(bus.mem_timeout), 32'd0);
    check("rst_count",  32'(bus.access_count), 32'd0);

    // LD, response in second read cycle
    bus.mem_op_valid = 1'b1; bus.mem_op = MOP_LD; #1;
    check("ld_acc_stall", 32'(bus.stall_pipe), 32'd1);
    check("ld_acc_read",  32'(bus.dcache_read), 32'd0);
    tick();
    bus.mem_op_valid = 1'b0; bus.mem_op = MOP_NONE; #1;
    check("ld_f1_read",  32'(bus.dcache_read), 32'd1);
    check("ld_f1_write", 32'(bus.dcache_write), 32'd0);
    check("ld_f1_stall", 32'(bus.stall_pipe), 32'd1);
    tick();
    bus.dcache_resp = 1'b1; #1;
    check("ld_f2_read", 32'(bus.dcache_read), 32'd1);
    check("ld_f2_done", 32'(bus.mem_done), 32'd0);
    tick();
    bus.dcache_resp = 1'b0; #1;
    check("ld_done",       32'(bus.mem_done), 32'd1);
    check("ld_done_stall", 32'(bus.stall_pipe), 32'd0);
    check("ld_done_read",  32'(bus.dcache_read), 32'd0);
    check("ld_count",      32'(bus.access_count), 32'd1);
    tick(); #1;
    check("ld_idle_done", 32'(bus.mem_done), 32'd0);

    // LDI, 1-cycle responses
    do_reset();
    bus.mem_op_valid = 1'b1; bus.mem_op = MOP_LDI; #1;
    check("ldi_acc_stall", 32'(bus.stall_pipe), 32'd1);
    tick();
    bus.mem_op_valid = 1'b0; bus.mem_op = MOP_NONE; bus.dcache_resp = 1'b1; #1;
    check("ldi_f_read",  32'(bus.dcache_read), 32'd1);
    check("ldi_f_lsave", 32'(bus.load_save), 32'd1);
    check("ldi_f_mux",   32'(bus.indirectmux_sel), 32'd0);
    check("ldi_f_done",  32'(bus.mem_done), 32'd0);
    tick(); #1;
    check("ldi_s_mux",   32'(bus.indirectmux_sel), 32'd1);
    check("ldi_s_read",  32'(bus.dcache_read), 32'd1);
    check("ldi_s_write", 32'(bus.dcache_write), 32'd0);
    check("ldi_s_sv",    32'(bus.save_valid), 32'd1);
    check("ldi_s_lsave", 32'(bus.load_save), 32'd0);
    check("ldi_s_done",  32'(bus.mem_done), 32'd0);
    tick();
    bus.dcache_resp = 1'b0; #1;
    check("ldi_done",    32'(bus.mem_done), 32'd1);
    check("ldi_done_sv", 32'(bus.save_valid), 32'd1);
    check("ldi_count",   32'(bus.access_count), 32'd2);
    tick(); #1;
    check("ldi_idle_sv", 32'(bus.save_valid), 32'd0);

    // STI: read pointer, then write through it
    do_reset();
    bus.mem_op_valid = 1'b1; bus.mem_op = MOP_STI; tick();
    bus.mem_op_valid = 1'b0; bus.mem_op = MOP_NONE; bus.dcache_resp = 1'b1; #1;
    check("sti_f_read",  32'(bus.dcache_read), 32'd1);
    check("sti_f_write", 32'(bus.dcache_write), 32'd0);
    tick(); #1;
    check("sti_s_write", 32'(bus.dcache_write), 32'd1);
    check("sti_s_read",  32'(bus.dcache_read), 32'd0);
    check("sti_s_mux",   32'(bus.indirectmux_sel), 32'd1);
    tick();
    bus.dcache_resp = 1'b0; #1;
    check("sti_done",    32'(bus.mem_done), 32'd1);
    check("sti_done_sv", 32'(bus.save_valid), 32'd1);
    tick();

    // ST with mem_op switched to LD mid-access
    do_reset();
    bus.mem_op_valid = 1'b1; bus.mem_op = MOP_ST; tick();
    bus.mem_op = MOP_LD; #1;
    check("st_chg_write", 32'(bus.dcache_write), 32'd1);
    check("st_chg_read",  32'(bus.dcache_read), 32'd0);
    tick(); #1;
    check("st_chg_write2", 32'(bus.dcache_write), 32'd1);
    bus.dcache_resp = 1'b1; tick();
    bus.dcache_resp = 1'b0; bus.mem_op_valid = 1'b0; bus.mem_op = MOP_NONE; #1;
    check("st_chg_done",   32'(bus.mem_done), 32'd1);
    check("st_chg_sv",     32'(bus.save_valid), 32'd0);
    tick();

    // Timeout: withhold response for 300 cycles
    do_reset();
    bus.mem_op_valid = 1'b1; bus.mem_op = MOP_LD; tick();
    bus.mem_op_valid = 1'b0; bus.mem_op = MOP_NONE;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 254) check("tmo_254", 32'(bus.mem_timeout), 32'd0);
      if (k == 255) check("tmo_255", 32'(bus.mem_timeout), 32'd1);
    end
    check("tmo_stall", 32'(bus.stall_pipe), 32'd1);
    check("tmo_read",  32'(bus.dcache_read), 32'd1);
    bus.dcache_resp = 1'b1; tick();
    bus.dcache_resp = 1'b0; #1;
    check("tmo_done",   32'(bus.mem_done), 32'd1);
    check("tmo_sticky", 32'(bus.mem_timeout), 32'd1);
    tick(); #1;
    check("tmo_idle",   32'(bus.mem_timeout), 32'd1);
    reset_n = 1'b0; #1;
    check("tmo_rst",    32'(bus.mem_timeout), 32'd0);

    // Reset during SECOND of an LDI
    do_reset();
    bus.mem_op_valid = 1'b1; bus.mem_op = MOP_LDI; tick();
    bus.dcache_resp = 1'b1; tick();
    bus.dcache_resp = 1'b0; #1;
    check("rs_s_mux",   32'(bus.indirectmux_sel), 32'd1);
    check("rs_s_count", 32'(bus.access_count), 32'd1);
    #1 reset_n = 1'b0; #1;
    check("rs_read",  32'(bus.dcache_read), 32'd0);
    check("rs_write", 32'(bus.dcache_write), 32'd0);
    check("rs_stall", 32'(bus.stall_pipe), 32'd0);
    check("rs_mux",   32'(bus.indirectmux_sel), 32'd0);
    check("rs_sv",    32'(bus.save_valid), 32'd0);
    check("rs_done",  32'(bus.mem_done), 32'd0);
    check("rs_count", 32'(bus.access_count), 32'd0);
    tick();
    reset_n = 1'b1; #1;
    check("rs_rel_stall", 32'(bus.stall_pipe), 32'd1);
    check("rs_rel_read",  32'(bus.dcache_read), 32'd0);
    check("rs_rel_mux",   32'(bus.indirectmux_sel), 32'd0);
    tick();
    bus.mem_op_valid = 1'b0; bus.mem_op = MOP_NONE; #1;
    check("rs_acc_read",  32'(bus.dcache_read), 32'd1);
    check("rs_acc_mux",   32'(bus.indirectmux_sel), 32'd0);
    do_reset();

    check("never_both", 32'(both_seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
